// File: rtl/data_sram_slave_pkg.sv
// Shared constants, bus payload and MMIO decode helpers for data_sram_slave.
// The optional TIMER register is built only when DSRAM_TIMER_EN is defined.
package data_sram_slave_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned LED_W  = 16;
    localparam int unsigned SW_W   = 16;
    localparam int unsigned OFF_W  = 16;

    localparam logic [DATA_W-1:0] MMIO_BASE_DEFAULT = 32'hBFAF_0000;

    localparam logic [OFF_W-1:0] OFF_LED     = 16'h0000;
    localparam logic [OFF_W-1:0] OFF_SWITCH  = 16'h0004;
    localparam logic [OFF_W-1:0] OFF_NUM     = 16'h0008;
    localparam logic [OFF_W-1:0] OFF_TIMER   = 16'h000C;
    localparam logic [OFF_W-1:0] OFF_SCRATCH = 16'h0010;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_LED,
        REG_SWITCH,
        REG_NUM,
        REG_TIMER,
        REG_SCRATCH
    } mmio_reg_e;

    typedef struct packed {
        logic              en;
        logic [BE_W-1:0]   wen;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    // Map a window offset onto the register it selects.
    function automatic mmio_reg_e decode_off(input logic [OFF_W-1:0] off);
        mmio_reg_e sel;
        case (off)
            OFF_LED:     sel = REG_LED;
            OFF_SWITCH:  sel = REG_SWITCH;
            OFF_NUM:     sel = REG_NUM;
            OFF_TIMER:   sel = REG_TIMER;
            OFF_SCRATCH: sel = REG_SCRATCH;
            default:     sel = REG_NONE;
        endcase
        return sel;
    endfunction

    // Replace only the byte lanes selected by be.
    function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_val,
                                                     input logic [DATA_W-1:0] wdata,
                                                     input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_sram_slave_bram_be.sv
// bram_be: single-port RAM with per-byte write enables and a registered read port.
// Contents are never reset; only the read register clears on rst.
module bram_be
    import data_sram_slave_pkg::*;
#(
    parameter int unsigned AW = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [BE_W-1:0]   we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic              rd_c;

    always_comb begin
        rd_c = en && (we == '0);
    end

    always_ff @(posedge clk) begin : write_port
        if (en) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read register holds its value on writes and idle cycles.
    always_ff @(posedge clk) begin : read_port
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_c) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_sram_slave.sv
// Data-side SRAM slave: aliased word RAM plus a small MMIO window (LED, SWITCH, NUM, TIMER, SCRATCH).
// Define DSRAM_TIMER_EN to build the free-running TIMER register at offset 0x000C.
module data_sram_slave
    import data_sram_slave_pkg::*;
#(
    parameter int unsigned       RAM_AW    = 14,
    parameter logic [DATA_W-1:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_sram_en,
    input  logic [BE_W-1:0]   data_sram_wen,
    input  logic [DATA_W-1:0] data_sram_addr,
    input  logic [DATA_W-1:0] data_sram_wdata,
    output logic [DATA_W-1:0] data_sram_rdata,
    input  logic [SW_W-1:0]   switch,
    output logic [LED_W-1:0]  led,
    output logic [DATA_W-1:0] num_data
);

    bus_req_t          req_c;
    logic              acc_c;
    logic              rd_c;
    logic              wr_c;
    logic              mmio_hit_c;
    logic              ram_en_c;
    mmio_reg_e         sel_c;
    logic [DATA_W-1:0] mmio_rd_c;
    logic [DATA_W-1:0] timer_rd_c;
    logic [DATA_W-1:0] ram_rdata;

    logic [LED_W-1:0]  led_q, led_d;
    logic [SW_W-1:0]   sw_q, sw_d;
    logic [DATA_W-1:0] num_q, num_d;
    logic [DATA_W-1:0] scratch_q, scratch_d;
    logic [DATA_W-1:0] mmio_rdata_q, mmio_rdata_d;
    logic              hit_q, hit_d;

    // Request decode; anything presented during reset is dropped here.
    always_comb begin : decode
        req_c      = '{en: data_sram_en, wen: data_sram_wen,
                       addr: data_sram_addr, wdata: data_sram_wdata};
        acc_c      = req_c.en && !rst;
        rd_c       = acc_c && (req_c.wen == '0);
        wr_c       = acc_c && (req_c.wen != '0);
        mmio_hit_c = (req_c.addr[31:16] == MMIO_BASE[31:16]);
        ram_en_c   = acc_c && !mmio_hit_c;
        sel_c      = decode_off(req_c.addr[OFF_W-1:0]);
    end

    always_comb begin : mmio_read_mux
        mmio_rd_c = '0;
        case (sel_c)
            REG_LED:     mmio_rd_c = DATA_W'(led_q);
            REG_SWITCH:  mmio_rd_c = DATA_W'(sw_q);
            REG_NUM:     mmio_rd_c = num_q;
            REG_TIMER:   mmio_rd_c = timer_rd_c;
            REG_SCRATCH: mmio_rd_c = scratch_q;
            default:     mmio_rd_c = '0;
        endcase
    end

    always_comb begin : next_state
        led_d        = led_q;
        sw_d         = switch;
        num_d        = num_q;
        scratch_d    = scratch_q;
        mmio_rdata_d = mmio_rdata_q;
        hit_d        = hit_q;
        if (wr_c && mmio_hit_c) begin
            case (sel_c)
                REG_LED:     led_d     = LED_W'(byte_merge(DATA_W'(led_q), req_c.wdata, req_c.wen));
                REG_NUM:     num_d     = byte_merge(num_q, req_c.wdata, req_c.wen);
                REG_SCRATCH: scratch_d = byte_merge(scratch_q, req_c.wdata, req_c.wen);
                default:     ;
            endcase
        end
        // Hit flag steers the output mux and only moves on reads, so rdata holds otherwise.
        if (rd_c) begin
            hit_d = mmio_hit_c;
            if (mmio_hit_c) mmio_rdata_d = mmio_rd_c;
        end
    end

    always_ff @(posedge clk) begin : regs
        if (rst) begin
            led_q        <= '0;
            sw_q         <= '0;
            num_q        <= '0;
            scratch_q    <= '0;
            mmio_rdata_q <= '0;
            hit_q        <= 1'b0;
        end else begin
            led_q        <= led_d;
            sw_q         <= sw_d;
            num_q        <= num_d;
            scratch_q    <= scratch_d;
            mmio_rdata_q <= mmio_rdata_d;
            hit_q        <= hit_d;
        end
    end

`ifdef DSRAM_TIMER_EN
    logic [DATA_W-1:0] timer_q, timer_d;

    // A write wins over the increment in the same cycle.
    always_comb begin : timer_next
        timer_d = timer_q + DATA_W'(1);
        if (wr_c && mmio_hit_c && (sel_c == REG_TIMER)) begin
            timer_d = byte_merge(timer_q, req_c.wdata, req_c.wen);
        end
    end

    always_ff @(posedge clk) begin : timer_reg
        if (rst) timer_q <= '0;
        else     timer_q <= timer_d;
    end

    assign timer_rd_c = timer_q;
`else
    assign timer_rd_c = '0;
`endif

    bram_be #(
        .AW(RAM_AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .en    (ram_en_c),
        .we    (req_c.wen),
        .addr  (req_c.addr[RAM_AW+1:2]),
        .wdata (req_c.wdata),
        .rdata (ram_rdata)
    );

    assign data_sram_rdata = hit_q ? mmio_rdata_q : ram_rdata;
    assign led             = led_q;
    assign num_data        = num_q;

endmodule
